// File: rtl/nested_array_pipe_reg_if.sv
// ---------------------------------------------------------------------------
// nested_array_pipe_reg_if
//
// Purpose: bundles the upstream (I side) and downstream (O side) valid/ready
// channels of nested_array_pipe_reg. Each channel carries an N-element array
// of WIDTH-bit words.
//
// Signals:
//   I_valid  upstream data valid                        (master -> slave)
//   I_ready  pipe can accept I this cycle               (slave  -> master)
//   I        input array [N-1:0][WIDTH-1:0]             (master -> slave)
//   O_valid  last stage holds valid data                (slave  -> master)
//   O_ready  downstream accepts O this cycle            (master -> slave)
//   O        output array [N-1:0][WIDTH-1:0]            (slave  -> master)
//
// Modports:
//   master - the environment around the pipe (producer + consumer)
//   slave  - the pipe itself
// ---------------------------------------------------------------------------
interface nested_array_pipe_reg_if #(
    parameter int WIDTH = 8,
    parameter int N     = 3
);
    logic                        I_valid;
    logic                        I_ready;
    logic [N-1:0][WIDTH-1:0]     I;
    logic                        O_valid;
    logic                        O_ready;
    logic [N-1:0][WIDTH-1:0]     O;

    modport master (
        output I_valid,
        output I,
        output O_ready,
        input  I_ready,
        input  O_valid,
        input  O
    );

    modport slave (
        input  I_valid,
        input  I,
        input  O_ready,
        output I_ready,
        output O_valid,
        output O
    );
endinterface

// File: rtl/nested_array_pipe_reg.sv
// ---------------------------------------------------------------------------
// nested_array_pipe_reg
//
// Purpose: a chain of DEPTH register stages, each holding an N x WIDTH array,
// with valid/ready flow control at both ends. Used to retime nested-array
// buses across long paths while keeping full throughput under backpressure.
// The ready chain is bubble-collapsing: an empty stage always accepts, so the
// pipe holds exactly DEPTH arrays and a full pipe with O_ready=1 still
// accepts a new array in the same cycle the oldest one leaves.
//
// Parameters:
//   WIDTH  bits per array element (>=1)
//   N      elements per array (>=1)
//   DEPTH  number of register stages (>=1)
//   INIT   N*WIDTH-bit flat reset value; element i = INIT[i*WIDTH +: WIDTH]
//
// Ports:
//   CLK          clock, rising edge
//   ASYNCRESETN  asynchronous active-low reset: empties the pipe, data = INIT
//   CLR          synchronous clear, active-high: same end state as reset,
//                and masks I_ready / O_valid during the clear cycle
//   bus          nested_array_pipe_reg_if.slave (I_valid/I_ready/I,
//                O_valid/O_ready/O)
//   COUNT        occupancy (number of valid stages), only when the macro
//                NESTED_PIPE_OCCUPANCY_EN is defined
//
// Optional feature (NESTED_PIPE_OCCUPANCY_EN):
//   Defined   - adds the COUNT output, a registered up/down occupancy
//               counter, and a simulation assertion tying it to the number of
//               valid stages.
//   Undefined - port, counter and assertion are absent.
// ---------------------------------------------------------------------------
module nested_array_pipe_reg #(
    parameter int                 WIDTH = 8,
    parameter int                 N     = 3,
    parameter int                 DEPTH = 2,
    parameter logic [N*WIDTH-1:0] INIT  = 24'hbeadde
) (
    input  logic                        CLK,
    input  logic                        ASYNCRESETN,
    input  logic                        CLR,
    nested_array_pipe_reg_if.slave      bus
`ifdef NESTED_PIPE_OCCUPANCY_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]  COUNT
`endif
);

    typedef logic [N-1:0][WIDTH-1:0] arr_t;

    // The packed [N-1:0][WIDTH-1:0] layout puts element 0 in the LSBs, which
    // is exactly the flat INIT layout, so a straight cast maps the elements.
    localparam arr_t INIT_ARR = arr_t'(INIT);

    // -----------------------------------------------------------------------
    // Stage state: one valid flop and one array register per stage.
    // Index 0 is the input side, DEPTH-1 drives O.
    // -----------------------------------------------------------------------
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    arr_t             d_q [DEPTH];
    arr_t             d_d [DEPTH];

    // rdy_chain[k] = stage k may load this cycle. Index DEPTH is the
    // downstream ready. A stage may load when it is empty or when the stage
    // in front of it is itself moving on.
    logic [DEPTH:0]   rdy_chain;

    always_comb begin
        rdy_chain        = '0;
        rdy_chain[DEPTH] = bus.O_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            rdy_chain[k] = ~v_q[k] | rdy_chain[k+1];
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic.
    // A stage whose upstream has no valid data still loads v (it becomes
    // empty) but keeps its old data; data is never replaced by INIT except
    // on reset or clear.
    // -----------------------------------------------------------------------
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (CLR) begin
            v_d = '0;
            for (int k = 0; k < DEPTH; k++) begin
                d_d[k] = INIT_ARR;
            end
        end else begin
            if (rdy_chain[0]) begin
                v_d[0] = bus.I_valid;
                if (bus.I_valid) begin
                    d_d[0] = bus.I;
                end
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (rdy_chain[k]) begin
                    v_d[k] = v_q[k-1];
                    if (v_q[k-1]) begin
                        d_d[k] = d_q[k-1];
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            v_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d_q[k] <= INIT_ARR;
            end
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. I_ready depends only on the v flops, O_ready and CLR, so it
    // reads 1 while reset is held. CLR masks both handshakes so neither side
    // counts a transfer in the clear cycle.
    // -----------------------------------------------------------------------
    assign bus.I_ready = rdy_chain[0] & ~CLR;
    assign bus.O_valid = v_q[DEPTH-1] & ~CLR;
    assign bus.O       = d_q[DEPTH-1];

`ifdef NESTED_PIPE_OCCUPANCY_EN
    // -----------------------------------------------------------------------
    // Occupancy counter: tracks transfers at both ends rather than summing
    // the v flops, so COUNT comes straight from a register.
    // -----------------------------------------------------------------------
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          in_xfer;
    logic          out_xfer;

    assign in_xfer  = bus.I_valid & bus.I_ready;
    assign out_xfer = bus.O_valid & bus.O_ready;

    always_comb begin
        count_d = count_q;
        if (CLR) begin
            count_d = '0;
        end else if (in_xfer && !out_xfer) begin
            count_d = count_q + CW'(1);
        end else if (out_xfer && !in_xfer) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign COUNT = count_q;

    // Counter and valid flops are updated from the same edge, so sampling
    // both at the clock edge compares consistent pre-update values.
    always @(posedge CLK) begin
        if (ASYNCRESETN) begin
            assert (int'(count_q) == $countones(v_q));
        end
    end
`endif

endmodule

// File: tb/tb_nested_array_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_nested_array_pipe_reg
//
// Two instances: the default configuration (WIDTH=8, N=3, DEPTH=2,
// INIT=24'hbeadde), exercised with directed sequences and random traffic
// against a queue-based reference model, and a minimal WIDTH=1, N=1,
// DEPTH=1, INIT=1 instance exercised with directed steps.
//
// Reference model: a FIFO of in-flight arrays, each tagged with how far it
// has travelled (0..DEPTH-1). Every cycle the oldest array leaves if it has
// arrived and the consumer is ready; every other array moves one step
// forward unless the array ahead of it is still occupying that spot.
// ---------------------------------------------------------------------------
module tb_nested_array_pipe_reg;

    localparam int          W     = 8;
    localparam int          NE    = 3;
    localparam int          D     = 2;
    localparam logic [23:0] INIT0 = 24'hbeadde;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic clr0  = 1'b0;
    logic clr1  = 1'b0;

    always #5 clk = ~clk;

    nested_array_pipe_reg_if #(.WIDTH(W), .N(NE)) bus0 ();
    nested_array_pipe_reg_if #(.WIDTH(1), .N(1))  bus1 ();

`ifdef NESTED_PIPE_OCCUPANCY_EN
    logic [1:0] count0;
    logic [0:0] count1;
`endif

    nested_array_pipe_reg #(
        .WIDTH(W), .N(NE), .DEPTH(D), .INIT(INIT0)
    ) dut0 (
        .CLK         (clk),
        .ASYNCRESETN (rst_n),
        .CLR         (clr0),
        .bus         (bus0)
`ifdef NESTED_PIPE_OCCUPANCY_EN
        ,
        .COUNT       (count0)
`endif
    );

    nested_array_pipe_reg #(
        .WIDTH(1), .N(1), .DEPTH(1), .INIT(1'b1)
    ) dut1 (
        .CLK         (clk),
        .ASYNCRESETN (rst_n),
        .CLR         (clr1),
        .bus         (bus1)
`ifdef NESTED_PIPE_OCCUPANCY_EN
        ,
        .COUNT       (count1)
`endif
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int in_xfers = 0;
    int out_xfers = 0;

    logic [23:0] out_log [$];
    int          out_cyc [$];

    typedef struct {
        logic [23:0] data;
        int          pos;
    } item_t;

    item_t       q [$];
    logic [23:0] last_out;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last_out = INIT0;
    endtask

    // One clock cycle on the default instance: drive, predict, compare,
    // then advance the model across the edge.
    task automatic cycle(input logic iv, input logic [23:0] id,
                         input logic ordy, input logic clr);
        item_t       nq [$];
        int          lim;
        int          np;
        logic        exp_ir;
        logic        exp_ov;
        logic [23:0] exp_o;
        logic        dut_in;
        logic        dut_out;

        @(negedge clk);
        bus0.I_valid = iv;
        bus0.I       = id;
        bus0.O_ready = ordy;
        clr0         = clr;
        #1;

        nq  = q;
        lim = D;
        if (!clr) begin
            if (nq.size() > 0 && nq[0].pos == D - 1 && ordy) begin
                void'(nq.pop_front());
            end
            foreach (nq[i]) begin
                np = nq[i].pos + 1;
                if (np > lim - 1) np = lim - 1;
                nq[i].pos = np;
                lim = np;
            end
        end
        exp_ir = !clr && (nq.size() == 0 || nq[nq.size()-1].pos > 0);
        exp_ov = !clr && q.size() > 0 && q[0].pos == D - 1;
        exp_o  = last_out;

        chk("i_ready", 32'(bus0.I_ready), 32'(exp_ir));
        chk("o_valid", 32'(bus0.O_valid), 32'(exp_ov));
        chk("o_data",  32'(bus0.O),       32'(exp_o));
`ifdef NESTED_PIPE_OCCUPANCY_EN
        chk("count",   32'(count0),       32'(q.size()));
`endif

        dut_in  = bus0.I_valid & bus0.I_ready;
        dut_out = bus0.O_valid & bus0.O_ready;
        if (dut_in)  in_xfers++;
        if (dut_out) begin
            out_xfers++;
            out_log.push_back(bus0.O);
            out_cyc.push_back(cyc);
        end
        if (dut_in || dut_out || clr) begin
            $display("cyc %0d clr=%0b in=%0b %h out=%0b %h",
                     cyc, clr, dut_in, id, dut_out, bus0.O);
        end

        @(posedge clk);
        if (clr) begin
            model_reset();
        end else begin
            q = nq;
            if (iv && exp_ir) q.push_back('{data: id, pos: 0});
            if (q.size() > 0 && q[0].pos == D - 1) last_out = q[0].data;
        end
        cyc++;
    endtask

    // Drop reset between clock edges and check outputs before any edge.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        clr0  = 1'b0;
        clr1  = 1'b0;
        rst_n = 1'b0;
        #1;
        chk({tag, "_o_valid"}, 32'(bus0.O_valid), 32'(0));
        chk({tag, "_o_data"},  32'(bus0.O),       32'(INIT0));
        chk({tag, "_i_ready"}, 32'(bus0.I_ready), 32'(1));
        chk({tag, "_t_o_valid"}, 32'(bus1.O_valid), 32'(0));
        chk({tag, "_t_o_data"},  32'(bus1.O),       32'(1));
        chk({tag, "_t_i_ready"}, 32'(bus1.I_ready), 32'(1));
`ifdef NESTED_PIPE_OCCUPANCY_EN
        chk({tag, "_count"},   32'(count0), 32'(0));
        chk({tag, "_t_count"}, 32'(count1), 32'(0));
`endif
        bus0.I_valid = 1'b0;
        bus1.I_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset %s applied", tag);
        model_reset();
    endtask

    initial begin
        int c0;
        int in0;
        int out0;
        logic iv;
        logic ordy;
        logic clr;

        bus0.I_valid = 1'b0;
        bus0.I       = '0;
        bus0.O_ready = 1'b0;
        bus1.I_valid = 1'b0;
        bus1.I       = '0;
        bus1.O_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        // 1: asynchronous reset between edges
        async_reset("t1");

        // 2: unstalled stream, two arrays back to back
        out_log.delete(); out_cyc.delete();
        c0 = cyc;
        cycle(1'b1, 24'h030201, 1'b1, 1'b0);
        cycle(1'b1, 24'h060504, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 24'h0, 1'b1, 1'b0);
        chk("t2_n_out",    32'(out_log.size()),     32'(2));
        chk("t2_first",    32'(out_log[0]),         32'h030201);
        chk("t2_first_at", 32'(out_cyc[0] - c0),    32'(2));
        chk("t2_second",   32'(out_log[1]),         32'h060504);
        chk("t2_second_at",32'(out_cyc[1] - c0),    32'(3));

        // 3: backpressure, third push refused until the first drains
        out_log.delete(); out_cyc.delete();
        in0 = in_xfers;
        cycle(1'b1, 24'h0a0a0a, 1'b0, 1'b0);
        cycle(1'b1, 24'h0b0b0b, 1'b0, 1'b0);
        cycle(1'b1, 24'h0c0c0c, 1'b0, 1'b0);
        chk("t3_in_stalled", 32'(in_xfers - in0), 32'(2));
        cycle(1'b1, 24'h0c0c0c, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 24'h0, 1'b1, 1'b0);
        chk("t3_n_out", 32'(out_log.size()), 32'(3));
        chk("t3_out0",  32'(out_log[0]), 32'h0a0a0a);
        chk("t3_out1",  32'(out_log[1]), 32'h0b0b0b);
        chk("t3_out2",  32'(out_log[2]), 32'h0c0c0c);

        // 4: full pipe streaming for 10 cycles
        cycle(1'b1, 24'h111111, 1'b0, 1'b0);
        cycle(1'b1, 24'h222222, 1'b0, 1'b0);
        in0  = in_xfers;
        out0 = out_xfers;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 24'($urandom), 1'b1, 1'b0);
        end
        chk("t4_in",  32'(in_xfers - in0),   32'(10));
        chk("t4_out", 32'(out_xfers - out0), 32'(10));

        // 5: clear while full, the pushed array must never appear
        out0 = out_xfers;
        cycle(1'b1, 24'hbad0ba, 1'b1, 1'b1);
        repeat (3) cycle(1'b0, 24'h0, 1'b1, 1'b0);
        chk("t5_no_out", 32'(out_xfers - out0), 32'(0));

        // random traffic with occasional clears and one mid-stream reset
        for (int i = 0; i < 600; i++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = (i % 100 < 50) ? ($urandom_range(0, 3) != 0)
                                  : ($urandom_range(0, 3) == 0);
            clr  = ($urandom_range(0, 40) == 0);
            cycle(iv, 24'($urandom), ordy, clr);
            if (i == 300) async_reset("mid");
        end
        clr0 = 1'b0;
        bus0.I_valid = 1'b0;

        // 6: minimal instance WIDTH=1, N=1, DEPTH=1, INIT=1
        async_reset("t6");
        @(negedge clk);
        bus1.I_valid = 1'b1;
        bus1.I       = 1'b0;
        bus1.O_ready = 1'b0;
        #1;
        chk("t6_ir_empty", 32'(bus1.I_ready), 32'(1));
        chk("t6_ov_empty", 32'(bus1.O_valid), 32'(0));
        chk("t6_o_init",   32'(bus1.O),       32'(1));
        @(negedge clk);
        bus1.I = 1'b1;
        #1;
        chk("t6_ov_full", 32'(bus1.O_valid), 32'(1));
        chk("t6_o_full",  32'(bus1.O),       32'(0));
        chk("t6_ir_full", 32'(bus1.I_ready), 32'(0));
`ifdef NESTED_PIPE_OCCUPANCY_EN
        chk("t6_count_full", 32'(count1), 32'(1));
`endif
        @(negedge clk);
        #1;
        chk("t6_ov_hold", 32'(bus1.O_valid), 32'(1));
        chk("t6_o_hold",  32'(bus1.O),       32'(0));
        bus1.O_ready = 1'b1;
        bus1.I_valid = 1'b0;
        #1;
        chk("t6_ir_drain", 32'(bus1.I_ready), 32'(1));
        $display("tiny out xfer data=%0b", bus1.O);
        @(negedge clk);
        #1;
        chk("t6_ov_after", 32'(bus1.O_valid), 32'(0));
        chk("t6_o_kept",   32'(bus1.O),       32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nested_array_pipe_reg.md
Name: nested_array_pipe_reg

Overview:
- Parametrised successor to the single nested-array reset register.
- Holds a chain of DEPTH register stages, each carrying an N-element array of WIDTH-bit words, with valid/ready flow control at both ends.
- Reset loads a per-element INIT value.
- Used to retime nested-array buses (for example Array[N, Bits[WIDTH]]) across long paths without losing throughput under backpressure.

Parameters:
WIDTH, 8, bits per array element (>=1)
N, 3, elements per array (>=1)
DEPTH, 2, number of register stages (>=1)
INIT, 24'hbeadde, N*WIDTH-bit flat init value; element i = INIT[i*WIDTH +: WIDTH] (element 0 in the LSBs)

Ports:
CLK  input  1  clock, posedge
ASYNCRESETN  input  1  asynchronous active-low reset
CLR  input  1  synchronous clear, active-high
I_valid  input  1  upstream data valid
I_ready  output  1  block can accept I this cycle
I  input  N x WIDTH  input array [N-1:0] of [WIDTH-1:0]
O_valid  output  1  output stage holds valid data
O_ready  input  1  downstream accepts O this cycle
O  output  N x WIDTH  output array, driven directly from the last stage's flops

Behaviour:
- Stage state:
  - v[k]: valid flop per stage, k = 0..DEPTH-1; stage 0 is the input side.
  - d[k]: N x WIDTH data flops per stage.
- Reset (ASYNCRESETN=0, takes effect immediately, independent of CLK):
  - all v[k]=0; all d[k]=INIT.
  - Outputs: O_valid=0, O=INIT, I_ready=1 (I_ready is combinational from the v flops, so it reads 1 while reset is held).
- Ready chain (combinational, bubble-collapsing):
  - r[DEPTH] = O_ready.
  - r[k] = !v[k] | r[k+1].
  - I_ready = r[0] & !CLR.
- Load rules on a posedge with CLR=0:
  - Stage 0: when r[0]=1, v[0] <= I_valid; d[0] <= I only if I_valid=1.
  - Stage k>0: when r[k]=1, v[k] <= v[k-1]; d[k] <= d[k-1] only if v[k-1]=1.
  - When r[k]=0, the stage holds both v and d.
  - When a stage empties, d keeps its last value; it is not overwritten with INIT.
- Transfers:
  - Input transfer = I_valid & I_ready.
  - Output transfer = O_valid & O_ready.
- O_valid = v[DEPTH-1] & !CLR; O = d[DEPTH-1].
- Timing:
  - Latency from input transfer to O_valid is exactly DEPTH cycles when unstalled.
  - Throughput is 1 array per cycle.
  - Full (all v=1) with O_ready=1: I_ready=1, so accept and drain happen in the same cycle.
  - Full with O_ready=0: I_ready=0.
- Ordering: strict FIFO; capacity is exactly DEPTH arrays.
- CLR=1 at a posedge:
  - Same end state as reset: all v=0, all d=INIT.
  - Overrides any transfer that cycle.
  - I_ready and O_valid are forced 0 during that cycle, so no transfer is counted by either side.
- Elements are opaque: no arithmetic, no reordering; element i of I arrives at element i of O.
- Reset asserted mid-stream discards all in-flight data. The first posedge after deassertion behaves as from the empty state.

Optional Feature:
- Macro: NESTED_PIPE_OCCUPANCY_EN.
- Defined:
  - Adds output port COUNT, width $clog2(DEPTH+1), equal to the number of v[k]=1, from a registered counter.
  - Counter update: +1 on input transfer only, -1 on output transfer only, unchanged on both or neither.
  - Reset and CLR set COUNT to 0.
  - An assertion checks COUNT equals popcount(v).
- Not defined: the port, the counter and the assertion are absent; behaviour is otherwise identical.

Test Plan:
1. Defaults; drop ASYNCRESETN between clock edges -> O_valid=0, O={8'hbe,8'had,8'hde} (element 2..0), I_ready=1, COUNT=0 without waiting for CLK.
2. Stream unstalled, O_ready=1: send {03,02,01} at cycle 0, {06,05,04} at cycle 1 -> O={03,02,01} valid at cycle 2, {06,05,04} at cycle 3, no bubbles.
3. O_ready=0 with 3 pushes -> first two accepted, I_ready=0 on third, COUNT=2. Then raise O_ready -> outputs in order, third accepted the same cycle the first drains.
4. Pipe full, I_valid=1 and O_ready=1 every cycle for 10 cycles -> I_ready stays 1, 10 transfers each side, COUNT stays 2.
5. Pipe full, CLR=1 one cycle with I_valid=1 -> I_ready=0 and O_valid=0 that cycle; next cycle O=INIT, O_valid=0, COUNT=0, the pushed array is never output.
6. WIDTH=1, N=1, DEPTH=1, INIT=1'b1 -> reset O=1; push 0 -> O=0 valid after 1 cycle; holds under O_ready=0 while I_ready=0.
